// File: rtl/fetch_pkg.sv
// Shared fetch types: instruction width, PC increment and the buffered {pc, instr} entry.
package fetch_pkg;

  localparam int ILEN = 32;
  localparam int PC_STEP = 4;
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Registered FIFO, no bypass: data pushed this cycle is visible at dout next cycle.
// Clear has priority over push/pop; pushing into a full FIFO without a pop is a caller error.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !clear));

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential fetch front-end: credit-limited requests, in-order responses buffered for decode.
// Grant->inst_valid is k+1 cycles; decode backpressure throttles requests via the FIFO credit.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [ILEN-1:0]   imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ILEN-1:0]   inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              flushing
);

  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0]    DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] target;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_next;
  logic [CNT_W-1:0]  discard;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              grant;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  fetch_entry_t      wr_entry;
  fetch_entry_t      head;

  assign target      = redirect_pc & ~ADDR_W'(3);
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};

  // rst_n gates the request so it drops the moment reset asserts, not at the next edge.
  assign imem_req  = rst_n && !redirect_valid && (credit_used < DEPTH_LIM);
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;

  assign outstanding_next = outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid);

  assign push     = imem_rvalid && !redirect_valid && (discard == '0);
  assign pop      = inst_valid && inst_ready && !redirect_valid;
  assign wr_entry = '{pc: 32'(resp_pc), instr: imem_rdata};

  assign inst_valid = !fifo_empty;
  assign inst_data  = inst_valid ? head.instr : '0;
  assign inst_pc    = inst_valid ? ADDR_W'(head.pc) : '0;
  assign flushing   = (discard != '0);

  // Everything still in flight after a redirect cycle belongs to the old path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        fetch_pc <= target;
        resp_pc  <= target;
        discard  <= outstanding_next;
      end else begin
        if (grant) fetch_pc <= fetch_pc + STEP;
        if (push)  resp_pc  <= resp_pc + STEP;
        if (imem_rvalid && (discard != '0)) discard <= discard - CNT_W'(1);
      end
    end
  end

  sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (redirect_valid),
    .din   (wr_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_full && push && !pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-based memory and decode-stream model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt = 1'b0;
  logic              imem_rvalid = 1'b0;
  logic [31:0]       imem_rdata = '0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              flushing;

  instr_fetch_unit #(
    .ADDR_W(ADDR_W), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .flushing(flushing)
  );

  always #5 clk = ~clk;

  // Memory model: each granted request carries the path epoch it was issued on.
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  req_t        pend[$];
  logic [31:0] buf_q[$];
  logic [31:0] next_fetch;
  int epoch, cyc, last_due, n_cmp, n_err, n_pop;
  int p_gnt, p_ready, p_redir, lat_max;
  bit fired;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (pend[i]) if (pend[i].epoch != epoch) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic knobs(input int g, input int r, input int rd, input int lat);
    p_gnt = g; p_ready = r; p_redir = rd; lat_max = lat;
  endtask

  // mode 0: random redirect, 1: forced redirect, 2: redirect only when a live response lands with a pop pending
  task automatic step(input int mode, input logic [31:0] pc_in);
    bit do_resp, do_redir, do_gnt, do_rdy, exp_req;
    logic [31:0] rpc;
    req_t r;
    int due;
    @(negedge clk);
    do_resp = (pend.size() > 0) && (pend[0].due <= cyc);
    do_gnt  = ($urandom_range(99) < p_gnt);
    do_rdy  = ($urandom_range(99) < p_ready);
    rpc     = pc_in;
    case (mode)
      0: begin
        do_redir = ($urandom_range(999) < p_redir);
        rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(31)))
                                       : 32'($urandom_range(16'hFFFF));
      end
      1: do_redir = 1'b1;
      default: begin
        do_redir = do_resp && (pend[0].epoch == epoch) && (buf_q.size() > 0);
        if (do_redir) begin do_rdy = 1'b1; fired = 1'b1; end
      end
    endcase
    imem_gnt       = do_gnt;
    imem_rvalid    = do_resp;
    imem_rdata     = do_resp ? word_of(pend[0].addr) : $urandom;
    redirect_valid = do_redir;
    redirect_pc    = rpc;
    inst_ready     = do_rdy;
    #1;
    exp_req = (buf_q.size() + pend.size() < DEPTH) && !do_redir;
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, next_fetch);
    chk("inst_valid", inst_valid, buf_q.size() != 0);
    if (buf_q.size() != 0) begin
      chk("inst_pc", inst_pc, buf_q[0]);
      chk("inst_data", inst_data, word_of(buf_q[0]));
    end
    chk("flushing", flushing, stale_cnt() != 0);

    // Model state after the coming rising edge.
    if (do_resp) r = pend.pop_front();
    if (do_redir) begin
      buf_q.delete();
      epoch++;
      next_fetch = rpc & ~32'h3;
    end else begin
      if (do_rdy && buf_q.size() > 0) begin
        void'(buf_q.pop_front());
        n_pop++;
      end
      if (do_resp && r.epoch == epoch) buf_q.push_back(r.addr);
      if (exp_req && do_gnt) begin
        due = cyc + $urandom_range(1, lat_max);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{next_fetch, due, epoch});
        next_fetch += 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_flushing", flushing, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc", inst_pc, 0);
    pend.delete();
    buf_q.delete();
    next_fetch = 32'h0;
    epoch++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_pop = 0; cyc = 0; epoch = 0; last_due = 0; fired = 1'b0;
    do_reset();

    knobs(100, 100, 0, 1); repeat (30) step(0, 0);
    knobs(100, 0, 0, 1);   repeat (15) step(0, 0);
    knobs(100, 100, 0, 1); repeat (20) step(0, 0);

    knobs(100, 100, 0, 3); repeat (6) step(0, 0);
    step(1, 32'h0000_0100);
    repeat (20) step(0, 0);

    knobs(100, 30, 0, 3); repeat (8) step(0, 0);
    for (int i = 0; i < 60 && !fired; i++) step(2, 32'h0000_0103);
    chk("redir_on_resp_hit", fired, 1);
    knobs(100, 100, 0, 3); repeat (20) step(0, 0);

    knobs(100, 100, 0, 2); step(1, 32'hFFFF_FFF8); repeat (20) step(0, 0);

    knobs(100, 0, 0, 1); repeat (12) step(0, 0);
    do_reset();
    knobs(100, 100, 0, 1); repeat (10) step(0, 0);

    for (int blk = 0; blk < 15; blk++) begin
      knobs($urandom_range(30, 100), $urandom_range(10, 100), $urandom_range(0, 30),
            $urandom_range(1, 4));
      repeat (200) step(0, 0);
    end

    chk("pops_seen", n_pop > 200, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Parametrised fetch front-end for the RISC-V core; replaces the bare PC register plus combinational instruction-memory read.
- Issues sequential word fetches to an instruction memory with variable-latency request/grant/response handshake and buffers returned instructions in a FIFO.
- Presents {pc, instr} to decode through a valid/ready interface and supports branch/jump redirect with flush of in-flight fetches.

Parameters:
ADDR_W, 32, width of PC and memory byte address
RESET_PC, 0, byte address fetched first after reset (bits [1:0] must be 0)
FIFO_DEPTH, 4, instruction buffer entries; power of two, >= 2; also bounds outstanding requests
CNT_W, $clog2(FIFO_DEPTH)+1, width of occupancy/outstanding counters (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  ADDR_W  byte address of request, word aligned
imem_gnt  input  1  request accepted this cycle (only meaningful with imem_req)
imem_rvalid  input  1  response data valid; responses return in request order
imem_rdata  input  32  instruction word
redirect_valid  input  1  branch/jump taken, restart fetch
redirect_pc  input  ADDR_W  new fetch address
inst_valid  output  1  buffered instruction available
inst_ready  input  1  decode accepts instruction
inst_data  output  32  instruction word
inst_pc  output  ADDR_W  byte address of inst_data
flushing  output  1  discarding stale responses

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, outstanding=0, discard=0; outputs imem_req=0, inst_valid=0, flushing=0, inst_data=0, inst_pc=0. Memory shares rst_n; no responses are expected after reset.
- Credit: imem_req = (fifo_count + outstanding < FIFO_DEPTH) && !redirect_valid. imem_addr = fetch_pc.
- Grant (imem_req && imem_gnt): fetch_pc += 4 (modulo 2^ADDR_W, wraps to 0), outstanding++.
- Response (imem_rvalid): outstanding--. If discard>0: discard--, data dropped. Else push {resp_pc, imem_rdata}; resp_pc += 4 (wraps).
- Latency: grant at cycle t, rvalid at t+k (k>=1), inst_valid at t+k+1 (registered FIFO, no bypass).
- Pop: inst_valid && inst_ready. inst_valid = FIFO not empty; inst_data/inst_pc = FIFO head, held stable while valid && !ready.
- Simultaneous push and pop: both occur, count unchanged. Overflow impossible by credit rule; a push to a full FIFO is a design error (assertion).
- Redirect (redirect_valid, highest priority): target = {redirect_pc[ADDR_W-1:2], 2'b00}. fetch_pc <= target, resp_pc <= target, FIFO cleared (pop in same cycle ignored), discard <= outstanding_next, i.e. outstanding after this cycle's grant (none, req is masked) and response (decrements). Response arriving in redirect cycle is dropped.
- flushing = (discard != 0). Redirect while already flushing recomputes discard as above (no double count).
- Zero-outstanding redirect: discard=0, fetching resumes next cycle at target.
- Back-to-back redirects: each restarts from its own target; last wins.
- Counters sized CNT_W; outstanding never exceeds FIFO_DEPTH.

Decomposition:
- Package fetch_pkg: ILEN=32, PC_STEP=4, INSTR_NOP=32'h0000_0013, typedef fetch_entry_t {pc, instr} (pc width fixed to 32 in package; ADDR_W<32 truncates).
- Sub-module sync_fifo (parametrised WIDTH, DEPTH; push, pop, clear, full, empty, count; async active-low reset) holding fetch_entry_t. Control, counters and redirect logic in instr_fetch_unit.

Test Plan:
- Reset RESET_PC=0, gnt=1 always, rvalid one cycle later, ready=1 -> imem_addr 0x0,0x4,0x8...; inst_pc 0x0,0x4,0x8 with matching rdata, first inst_valid 2 cycles after first grant.
- ready=0, FIFO_DEPTH=4 -> exactly 4 grants, then imem_req=0; ready=1 -> fetch resumes at 0x10, no lost or duplicated instruction.
- 2 outstanding (memory latency 3), redirect_pc=0x100 -> flushing=1, next 2 rvalid dropped, first inst_pc=0x100, FIFO prior contents gone.
- redirect_pc=0x103 in same cycle as rvalid and pending pop -> target 0x100, that response dropped, pop ignored, discard = remaining outstanding.
- RESET_PC=0xFFFF_FFF8 -> inst_pc FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- rst_n low mid-stream with full FIFO -> imem_req, inst_valid, flushing 0 immediately (before next edge); after release fetch restarts at RESET_PC.
